q1: RTL and testbench

- Four-input truth-table block: computes two Boolean functions of inputs a, b, c and d.
  - f = odd parity of the four inputs.
  - g = primality of the 4-bit value {a,b,c,d}.
- Used as a small decode/classification leaf wherever a 4-bit code must be checked for parity and membership in a fixed set.
- Outputs can be registered and inputs optionally synchronized, so the block can sit directly on asynchronous pins.

---
 rtl/q1.sv | 149 ++++++++++++++
 tb/tb_q1.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/q1.sv
// -----------------------------------------------------------------------------
// q1 : four-input parity / primality classifier.
//
// Purpose:
//   Decodes the 4-bit code N = {a,b,c,d} (a = MSB) into two flags:
//     f = odd parity of the four bits (a^b^c^d)
//     g = 1 when N is prime (2,3,5,7,11,13)
//   The inputs can pass through an optional synchronizer chain, so the block
//   can be wired directly to asynchronous pins. The flags can be taken from
//   output flops or straight from the decoder.
//
// Parameters:
//   SYNC_STAGES : flop stages on a..d before decoding (0..3). Any other value
//                 stops elaboration.
//   REG_OUT     : 1 = f/g come from flops, 0 = f/g come from the decoder.
//   The latency from an input change to f/g is SYNC_STAGES + REG_OUT cycles.
//
// Ports:
//   clk       in   1  system clock, rising edge
//   rst_n     in   1  async assert, active-low reset
//   a,b,c,d   in   1  code bits 3..0
//   f         out  1  odd parity of the code
//   g         out  1  code is prime
//   prime_cnt out  8  saturating count of clock edges where g = 1
//                     (this port exists only when Q1_PRIME_COUNT_EN is defined)
//
// Optional feature macro: Q1_PRIME_COUNT_EN
// -----------------------------------------------------------------------------
module q1 #(
  parameter int SYNC_STAGES = 0,
  parameter bit REG_OUT     = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  output logic       f,
  output logic       g
`ifdef Q1_PRIME_COUNT_EN
  ,
  output logic [7:0] prime_cnt
`endif
);

  // Odd parity of a 4-bit code.
  function automatic logic parity4(input logic [3:0] code);
    return code[3] ^ code[2] ^ code[1] ^ code[0];
  endfunction

  // Primality lookup for a 4-bit code. 0 and 1 are not prime.
  function automatic logic prime4(input logic [3:0] code);
    logic res;
    case (code)
      4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13: res = 1'b1;
      default:                              res = 1'b0;
    endcase
    return res;
  endfunction

  logic [3:0] code_s;  // code after the synchronizer, if there is one
  logic       f_d;
  logic       g_d;

  // An illegal depth has to stop the build. It must not be clamped.
  if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("q1: SYNC_STAGES must be in 0..3");
  end

  if (SYNC_STAGES == 0) begin : g_nosync
    assign code_s = {a, b, c, d};
  end else begin : g_sync
    logic [3:0] sync_q [SYNC_STAGES];

    // Synchronizer chain. Stage 0 samples the pins, and the last stage feeds
    // the decoder.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < SYNC_STAGES; i++) begin
          sync_q[i] <= 4'd0;
        end
      end else begin
        sync_q[0] <= {a, b, c, d};
        for (int i = 1; i < SYNC_STAGES; i++) begin
          sync_q[i] <= sync_q[i-1];
        end
      end
    end

    assign code_s = sync_q[SYNC_STAGES-1];
  end

  // Decode the (synchronized) code into the parity and prime flags.
  always_comb begin
    f_d = parity4(code_s);
    g_d = prime4(code_s);
  end

  if (REG_OUT) begin : g_regout
    logic f_q;
    logic g_q;

    // Output flops. They are cleared during reset, so both flags read 0.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        f_q <= 1'b0;
        g_q <= 1'b0;
      end else begin
        f_q <= f_d;
        g_q <= g_d;
      end
    end

    assign f = f_q;
    assign g = g_q;
  end else begin : g_combout
    assign f = f_d;
    assign g = g_d;
  end

`ifdef Q1_PRIME_COUNT_EN
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Count the edges that see g high. The count holds at 255 rather than
  // wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (g && (cnt_q != 8'd255)) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign prime_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_q1.sv
// -----------------------------------------------------------------------------
// tb_q1 : directed, table-driven bench for q1.
//
// Three instances share the same stimulus:
//   u_def  : defaults (SYNC_STAGES=0, REG_OUT=1)  -> 1-cycle latency
//   u_s2   : SYNC_STAGES=2, REG_OUT=1             -> 3-cycle latency
//   u_comb : SYNC_STAGES=0, REG_OUT=0             -> combinational
// Inputs change shortly after a falling edge. Outputs are sampled on falling
// edges or a few ns after a change, always away from the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_q1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
  logic f_def, g_def, f_s2, g_s2, f_comb, g_comb;
`ifdef Q1_PRIME_COUNT_EN
  logic [7:0] pc_def, pc_s2, pc_comb;
`endif

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [3:0] n;
    logic       f;
    logic       g;
  } vec_t;

  vec_t vt [16];

  always #5 clk = ~clk;

  q1 #(.SYNC_STAGES(0), .REG_OUT(1'b1)) u_def (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .f(f_def), .g(g_def)
`ifdef Q1_PRIME_COUNT_EN
    , .prime_cnt(pc_def)
`endif
  );

  q1 #(.SYNC_STAGES(2), .REG_OUT(1'b1)) u_s2 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .f(f_s2), .g(g_s2)
`ifdef Q1_PRIME_COUNT_EN
    , .prime_cnt(pc_s2)
`endif
  );

  q1 #(.SYNC_STAGES(0), .REG_OUT(1'b0)) u_comb (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .f(f_comb), .g(g_comb)
`ifdef Q1_PRIME_COUNT_EN
    , .prime_cnt(pc_comb)
`endif
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic set_n(input logic [3:0] n);
    {a, b, c, d} = n;
  endtask

  initial begin
    // Expected flags, derived by hand from the parity and prime sets.
    vt[0]  = '{4'd0,  1'b0, 1'b0};
    vt[1]  = '{4'd1,  1'b1, 1'b0};
    vt[2]  = '{4'd2,  1'b1, 1'b1};
    vt[3]  = '{4'd3,  1'b0, 1'b1};
    vt[4]  = '{4'd4,  1'b1, 1'b0};
    vt[5]  = '{4'd5,  1'b0, 1'b1};
    vt[6]  = '{4'd6,  1'b0, 1'b0};
    vt[7]  = '{4'd7,  1'b1, 1'b1};
    vt[8]  = '{4'd8,  1'b1, 1'b0};
    vt[9]  = '{4'd9,  1'b0, 1'b0};
    vt[10] = '{4'd10, 1'b0, 1'b0};
    vt[11] = '{4'd11, 1'b1, 1'b1};
    vt[12] = '{4'd12, 1'b0, 1'b0};
    vt[13] = '{4'd13, 1'b1, 1'b1};
    vt[14] = '{4'd14, 1'b1, 1'b0};
    vt[15] = '{4'd15, 1'b0, 1'b0};

    // --- Reset: hold N=7 with rst_n low across several edges ---
    rst_n = 1'b0;
    set_n(4'd7);
    repeat (3) @(negedge clk);
    chk("rst_f_def", {7'd0, f_def}, 8'd0);
    chk("rst_g_def", {7'd0, g_def}, 8'd0);
    chk("rst_f_s2",  {7'd0, f_s2},  8'd0);
    chk("rst_g_s2",  {7'd0, g_s2},  8'd0);
    // The combinational instance has no state, so it follows N=7 even in reset.
    chk("rst_f_comb", {7'd0, f_comb}, 8'd1);
    chk("rst_g_comb", {7'd0, g_comb}, 8'd1);
    rst_n = 1'b1;
    #1;
    chk("rel_pre_edge_g", {7'd0, g_def}, 8'd0);
    @(negedge clk);
    chk("rel_1edge_f", {7'd0, f_def}, 8'd1);
    chk("rel_1edge_g", {7'd0, g_def}, 8'd1);

    // --- Exhaustive sweep: each N is held for 20 ns ---
    for (int i = 0; i < 16; i++) begin
      set_n(vt[i].n);
      #1;
      chk($sformatf("comb_f_n%0d", i), {7'd0, f_comb}, {7'd0, vt[i].f});
      chk($sformatf("comb_g_n%0d", i), {7'd0, g_comb}, {7'd0, vt[i].g});
      @(negedge clk);
      chk($sformatf("def_f_n%0d", i), {7'd0, f_def}, {7'd0, vt[i].f});
      chk($sformatf("def_g_n%0d", i), {7'd0, g_def}, {7'd0, vt[i].g});
      @(negedge clk);
    end

    // --- Latency of the SYNC_STAGES=2 instance: change N from 0 to 13 ---
    set_n(4'd0);
    repeat (4) @(negedge clk);
    set_n(4'd13);
    @(negedge clk);
    chk("lat_e1_g", {7'd0, g_s2}, 8'd0);
    chk("lat_def_e1_g", {7'd0, g_def}, 8'd1);
    @(negedge clk);
    chk("lat_e2_f", {7'd0, f_s2}, 8'd0);
    chk("lat_e2_g", {7'd0, g_s2}, 8'd0);
    @(negedge clk);
    chk("lat_e3_f", {7'd0, f_s2}, 8'd1);
    chk("lat_e3_g", {7'd0, g_s2}, 8'd1);

    // --- Combinational: N=5 resolves with no clock edge in between ---
    #1;
    set_n(4'd5);
    #2;
    chk("comb5_f", {7'd0, f_comb}, 8'd0);
    chk("comb5_g", {7'd0, g_comb}, 8'd1);

    // --- Async reset mid-run: N=3 gives f/g = 0/1, then pulse reset ---
    @(negedge clk);
    set_n(4'd3);
    repeat (3) @(negedge clk);
    chk("ar_pre_f", {7'd0, f_def}, 8'd0);
    chk("ar_pre_g", {7'd0, g_def}, 8'd1);
    chk("ar_pre_g_s2", {7'd0, g_s2}, 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_drop_g", {7'd0, g_def}, 8'd0);
    chk("ar_drop_g_s2", {7'd0, g_s2}, 8'd0);
    chk("ar_comb_g", {7'd0, g_comb}, 8'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ar_rel_g", {7'd0, g_def}, 8'd1);
    chk("ar_rel_g_s2", {7'd0, g_s2}, 8'd0);

`ifdef Q1_PRIME_COUNT_EN
    // --- Prime counter: hold N=2 from a fresh reset and watch it saturate ---
    rst_n = 1'b0;
    set_n(4'd2);
    #1;
    chk("pc_rst0", pc_def, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // Edge 1 loads g=1. Edges 2..k count, so the count is k-1 after k edges.
    repeat (10) @(negedge clk);
    chk("pc_10edges", pc_def, 8'd9);
    chk("pc_comb_10edges", pc_comb, 8'd10);
    repeat (290) @(negedge clk);
    chk("pc_sat", pc_def, 8'd255);
    @(negedge clk);
    chk("pc_hold", pc_def, 8'd255);
    rst_n = 1'b0;
    #1;
    chk("pc_clear", pc_def, 8'd0);
    chk("pc_s2_clear", pc_s2, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
